dmem_responder: RTL and testbench

- Data-memory slave answering the core's DBUS master port: address, read enable, write enable and write data in; read data and a stall request out.
- Holds a word-organised on-chip RAM and a programmable wait-state counter, so core stall and forwarding paths can be exercised against a non-zero-latency memory.
- Sits at the SoC top level between the core's DBUS outputs and its i_dMEM_Read_Data / stall inputs.

---
 rtl/dmem_responder.sv | 179 +++++++++++++++++
 tb/tb_dmem_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Data-memory slave for the core's DBUS master port. It holds a word-organised
// on-chip RAM behind a programmable number of wait states. This lets the core's
// stall and forwarding paths run against a memory with non-zero latency.
//
// Every accepted access (read, write or erroneous) produces a single response
// cycle (o_dMEM_Valid). That cycle comes WAIT_STATES+1 edges after the accept.
// While the access is waiting, o_dMEM_Busy asks the pipeline to stall.
//
// Ports
//   i_Clk              system clock, rising edge
//   i_Rstn             asynchronous active-low reset
//   i_dMEM_Addr        byte address from the core
//   i_dMEM_ReadEn      read request
//   i_dMEM_WriteEn     write request
//   i_dMEM_Write_Data  store data
//   o_dMEM_Read_Data   registered load data, held until the next read response
//   o_dMEM_Valid       one-cycle response strobe for reads and writes
//   o_dMEM_Busy        stall request while an access is in its wait states
//   o_dMEM_Err         one-cycle strobe with Valid marking a failed access
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic              i_Clk,
  input  logic              i_Rstn,
  input  logic [ADDR_W-1:0] i_dMEM_Addr,
  input  logic              i_dMEM_ReadEn,
  input  logic              i_dMEM_WriteEn,
  input  logic [DATA_W-1:0] i_dMEM_Write_Data,
  output logic [DATA_W-1:0] o_dMEM_Read_Data,
  output logic              o_dMEM_Valid,
  output logic              o_dMEM_Busy,
  output logic              o_dMEM_Err
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  // Parameter sanity checks, evaluated at elaboration.
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : gBadWait
    $error("dmem_responder: WAIT_STATES must be in 0..15");
  end
  if (DATA_W != 32) begin : gBadData
    $error("dmem_responder: DATA_W must be 32");
  end
  if ((1 << IW) != DEPTH_WORDS) begin : gBadDepth
    $error("dmem_responder: DEPTH_WORDS must be a power of two");
  end
  if (ADDR_W < IW + 2) begin : gBadAddr
    $error("dmem_responder: ADDR_W too narrow for DEPTH_WORDS");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IW-1:0]     idxCap_q;
  logic [DATA_W-1:0] wdCap_q;
  logic              wrCap_q;
  logic              errCap_q;
  logic [DATA_W-1:0] rdata_q;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic              reqIn;
  logic              upperNz;
  logic              inErr;
  logic [IW-1:0]     inIdx;
  logic              accept;
  logic              enterResp;
  logic [IW-1:0]     accIdx;
  logic [DATA_W-1:0] accWd;
  logic              accWr;
  logic              accErr;

  // Any address bit above the word index field makes the access out of range.
  if (ADDR_W > IW + 2) begin : gUpper
    assign upperNz = |i_dMEM_Addr[ADDR_W-1:IW+2];
  end else begin : gNoUpper
    assign upperNz = 1'b0;
  end

  assign reqIn = i_dMEM_ReadEn | i_dMEM_WriteEn;
  assign inIdx = i_dMEM_Addr[2 +: IW];
  assign inErr = (i_dMEM_Addr[1:0] != 2'b00) | upperNz | (i_dMEM_ReadEn & i_dMEM_WriteEn);

  // Next-state logic. RESP accepts a new request just like IDLE does, so
  // back-to-back accesses run at one per WAIT_STATES+1 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (reqIn) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The RAM access happens on the edge that enters RESP. Coming out of WAIT,
  // it uses the captured request. With zero wait states the accept edge is
  // also the RESP edge, so it uses the live inputs instead.
  assign enterResp = (state_d == RESP);
  assign accIdx    = (state_q == WAIT) ? idxCap_q : inIdx;
  assign accWd     = (state_q == WAIT) ? wdCap_q  : i_dMEM_Write_Data;
  assign accWr     = (state_q == WAIT) ? wrCap_q  : i_dMEM_WriteEn;
  assign accErr    = (state_q == WAIT) ? errCap_q : inErr;

  always_ff @(posedge i_Clk or negedge i_Rstn) begin
    if (!i_Rstn) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      idxCap_q <= '0;
      wdCap_q  <= '0;
      wrCap_q  <= 1'b0;
      errCap_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idxCap_q <= inIdx;
        wdCap_q  <= i_dMEM_Write_Data;
        wrCap_q  <= i_dMEM_WriteEn;
        errCap_q <= inErr;
      end
      // Failed accesses return zero; writes leave the last load data in place.
      if (enterResp) begin
        if (accErr) begin
          rdata_q <= '0;
        end else if (!accWr) begin
          rdata_q <= mem[accIdx];
        end
      end
    end
  end

  // RAM array has no reset. A reset taken during WAIT drops the captured
  // write before it ever reaches this port.
  always_ff @(posedge i_Clk) begin
    if (enterResp && accWr && !accErr) begin
      mem[accIdx] <= accWd;
    end
  end

  assign o_dMEM_Read_Data = rdata_q;
  assign o_dMEM_Valid     = (state_q == RESP);
  assign o_dMEM_Busy      = (state_q == WAIT);
  assign o_dMEM_Err       = (state_q == RESP) & errCap_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Three responders with 0, 1 and 3 wait states share one clock. Each has its
// own reset and request lines. Directed steps issue accesses to one responder
// at a time. Each step pushes the expected response onto a scoreboard. A
// negedge monitor pops and compares the entry when Valid appears.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  typedef struct {
    int          dut;
    int          atEdge;
    bit          err;
    logic [31:0] rdata;
    int          busy;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN   [3];
  logic        rdEn   [3];
  logic        wrEn   [3];
  logic [31:0] addrI  [3];
  logic [31:0] wdI    [3];
  logic [31:0] rdO    [3];
  logic        validO [3];
  logic        busyO  [3];
  logic        errO   [3];

  int          vectors = 0;
  int          miscompares = 0;
  int          edgeCnt = 0;
  int          busyCnt [3];
  exp_t        sb [$];
  logic [31:0] model [3][1024];
  logic [31:0] lastRd [3];

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Edge counter used to time-stamp accepts and check response latency.
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // One responder per wait-state setting under test.
  for (genvar g = 0; g < 3; g++) begin : gDut
    dmem_responder #(
      .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) uDut (
      .i_Clk             (clk),
      .i_Rstn            (rstN[g]),
      .i_dMEM_Addr       (addrI[g]),
      .i_dMEM_ReadEn     (rdEn[g]),
      .i_dMEM_WriteEn    (wrEn[g]),
      .i_dMEM_Write_Data (wdI[g]),
      .o_dMEM_Read_Data  (rdO[g]),
      .o_dMEM_Valid      (validO[g]),
      .o_dMEM_Busy       (busyO[g]),
      .o_dMEM_Err        (errO[g])
    );
  end

  function automatic int wsOf(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor: counts busy cycles between responses and scores each Valid
  // against the oldest scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (busyO[d] === 1'b1) busyCnt[d]++;
      if (validO[d] === 1'b1) begin
        vectors++;
        assert (sb.size() != 0) else begin
          miscompares++;
          $error("[TB] FAIL unexpected_valid dut%0d observed valid=1 expected none", d);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          cmp({e.tag, "_dut"},     32'(d),          32'(e.dut));
          cmp({e.tag, "_latency"}, 32'(edgeCnt),    32'(e.atEdge));
          cmp({e.tag, "_err"},     {31'b0, errO[d]}, {31'b0, e.err});
          cmp({e.tag, "_rdata"},   rdO[d],          e.rdata);
          cmp({e.tag, "_busy"},    32'(busyCnt[d]), 32'(e.busy));
        end
        busyCnt[d] = 0;
      end
    end
  end

  // Reference behaviour: decode, error rules, RAM contents and held load data.
  task automatic expectAccess(input int d, input bit rd, input bit wr,
                              input logic [31:0] addr, input logic [31:0] data,
                              input string tag);
    exp_t e;
    logic [9:0] idx;
    bit err;
    idx = addr[11:2];
    err = (addr[1:0] != 2'b00) || (addr[31:12] != 20'd0) || (rd && wr);
    e.dut    = d;
    e.atEdge = edgeCnt + wsOf(d);
    e.busy   = wsOf(d);
    e.err    = err;
    e.tag    = tag;
    if (err) begin
      e.rdata   = 32'd0;
      lastRd[d] = 32'd0;
    end else if (wr) begin
      model[d][idx] = data;
      e.rdata = lastRd[d];
    end else begin
      e.rdata   = model[d][idx];
      lastRd[d] = e.rdata;
    end
    sb.push_back(e);
  endtask

  // Single access with a one-cycle gap before it. Inputs are held through
  // the wait states, or scrambled there when 'scramble' is set.
  task automatic applyStimulus(input int d, input bit rd, input bit wr,
                               input logic [31:0] addr, input logic [31:0] data,
                               input bit scramble, input string tag);
    @(posedge clk); #1;
    rdEn[d] = rd; wrEn[d] = wr; addrI[d] = addr; wdI[d] = data;
    @(posedge clk); #1;
    expectAccess(d, rd, wr, addr, data, tag);
    for (int i = 0; i < wsOf(d); i++) begin
      if (scramble) begin
        addrI[d] = addr ^ 32'h4;
        wdI[d]   = ~data;
      end
      @(posedge clk); #1;
    end
    rdEn[d] = 1'b0; wrEn[d] = 1'b0;
  endtask

  // Bounded wait for the scoreboard to drain; an expired bound is a failure.
  task automatic checkOutput(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("[TB] FAIL %s_drain observed pending=%0d expected pending=0", tag, sb.size());
      sb.delete();
    end
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    for (int d = 0; d < 3; d++) begin
      rstN[d] = 1'b0; rdEn[d] = 1'b0; wrEn[d] = 1'b0;
      addrI[d] = '0; wdI[d] = '0; busyCnt[d] = 0; lastRd[d] = '0;
    end
    #12;
    for (int d = 0; d < 3; d++) begin
      cmp($sformatf("reset_rdata%0d", d), rdO[d], 32'd0);
      cmp($sformatf("reset_valid%0d", d), {31'b0, validO[d]}, 32'd0);
      cmp($sformatf("reset_busy%0d", d),  {31'b0, busyO[d]},  32'd0);
      cmp($sformatf("reset_err%0d", d),   {31'b0, errO[d]},   32'd0);
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) rstN[d] = 1'b1;

    // One wait state: write/read, error cases, conflicting enables.
    applyStimulus(1, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, "ws1_wr10");
    applyStimulus(1, 1, 0, 32'h0000_0010, 32'h0,         0, "ws1_rd10");
    applyStimulus(1, 1, 0, 32'h0000_0002, 32'h0,         0, "ws1_misalign");
    applyStimulus(1, 0, 1, 32'h0000_0000, 32'h0000_0055, 0, "ws1_wr0");
    applyStimulus(1, 0, 1, 32'h0000_1000, 32'h0000_0099, 0, "ws1_wr_oor");
    applyStimulus(1, 1, 0, 32'h0000_0000, 32'h0,         0, "ws1_rd0");
    applyStimulus(1, 0, 1, 32'h0000_0020, 32'h0000_0077, 0, "ws1_wr20");
    applyStimulus(1, 1, 1, 32'h0000_0020, 32'hFFFF_0000, 0, "ws1_both");
    applyStimulus(1, 1, 0, 32'h0000_0020, 32'h0,         0, "ws1_rd20");
    checkOutput("ws1");

    // Zero wait states: back-to-back writes, then back-to-back reads.
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      wrEn[0] = 1'b1; rdEn[0] = 1'b0; addrI[0] = 32'(i * 4); wdI[0] = 32'(i + 1);
      @(posedge clk); #1;
      expectAccess(0, 0, 1, 32'(i * 4), 32'(i + 1), $sformatf("ws0_wr%0d", i));
    end
    wrEn[0] = 1'b0;
    checkOutput("ws0_wr");
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      rdEn[0] = 1'b1; addrI[0] = 32'(i * 4);
      @(posedge clk); #1;
      expectAccess(0, 1, 0, 32'(i * 4), 32'h0, $sformatf("ws0_rd%0d", i));
    end
    rdEn[0] = 1'b0;
    checkOutput("ws0_rd");

    // Three wait states: inputs changed while stalled must be ignored.
    applyStimulus(2, 0, 1, 32'h0000_0084, 32'h1111_2222, 0, "ws3_wr84");
    applyStimulus(2, 0, 1, 32'h0000_0040, 32'hAAAA_5555, 0, "ws3_wr40");
    applyStimulus(2, 0, 1, 32'h0000_0080, 32'hCAFE_F00D, 1, "ws3_hold_wr80");
    applyStimulus(2, 1, 0, 32'h0000_0080, 32'h0,         1, "ws3_rd80");
    applyStimulus(2, 1, 0, 32'h0000_0084, 32'h0,         0, "ws3_rd84");
    checkOutput("ws3");

    // Asynchronous reset in the middle of a read's wait states.
    @(posedge clk); #1;
    rdEn[2] = 1'b1; addrI[2] = 32'h0000_0040;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rstN[2] = 1'b0;
    #1;
    cmp("midwait_rst_rdata", rdO[2], 32'd0);
    cmp("midwait_rst_valid", {31'b0, validO[2]}, 32'd0);
    cmp("midwait_rst_busy",  {31'b0, busyO[2]},  32'd0);
    cmp("midwait_rst_err",   {31'b0, errO[2]},   32'd0);
    rdEn[2] = 1'b0;
    @(posedge clk); #1;
    rstN[2] = 1'b1; lastRd[2] = '0; busyCnt[2] = 0;
    @(posedge clk); #1;
    cmp("post_rst_busy",  {31'b0, busyO[2]},  32'd0);
    cmp("post_rst_valid", {31'b0, validO[2]}, 32'd0);
    applyStimulus(2, 1, 0, 32'h0000_0040, 32'h0, 0, "post_rst_rd40");
    checkOutput("post_rst");

    // Reset while a write is waiting: the RAM must keep its prior value.
    @(posedge clk); #1;
    wrEn[2] = 1'b1; addrI[2] = 32'h0000_0040; wdI[2] = 32'h1234_5678;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rstN[2] = 1'b0;
    #2;
    wrEn[2] = 1'b0;
    @(posedge clk); #1;
    rstN[2] = 1'b1; lastRd[2] = '0; busyCnt[2] = 0;
    applyStimulus(2, 1, 0, 32'h0000_0040, 32'h0, 0, "abort_wr_rd40");
    checkOutput("abort_wr");

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
